// File: rtl/ysyx_23060191_if_id_buf.sv
// IF/ID instruction buffer: small FIFO of {pc, inst} between fetch and decode.
// A flush (taken jump) empties it and drops the same-cycle push.
module ysyx_23060191_if_id_buf #(
    parameter int CPU_WIDTH = 32,
    parameter int DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CPU_WIDTH-1:0]         in_pc,
    input  logic [CPU_WIDTH-1:0]         in_inst,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CPU_WIDTH-1:0]         out_pc,
    output logic [CPU_WIDTH-1:0]         out_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [CPU_WIDTH-1:0] pc_mem   [DEPTH];
    logic [CPU_WIDTH-1:0] inst_mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop;

    // No pass-through when full: a same-cycle pop does not open a slot.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0) & ~flush;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_inst  = inst_mem[rd_ptr];
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= in_pc;
                inst_mem[wr_ptr] <= in_inst;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_ysyx_23060191_if_id_buf.sv
// Bench for the IF/ID buffer: directed scenarios plus random traffic against a queue model.
module tb_ysyx_23060191_if_id_buf;
    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rstn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_pc, in_inst, out_pc, out_inst;
    logic [1:0]   count;

    int tests = 0;
    int fails = 0;
    logic [63:0] q[$];   // model contents, head at index 0: {pc, inst}

    ysyx_23060191_if_id_buf #(.CPU_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    // Apply inputs just after a falling edge and let combinational outputs settle.
    task automatic drive(input logic v, input logic [W-1:0] pc, input logic [W-1:0] inst,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
        #1;
    endtask

    // Advance the model across one rising edge using the buffer's transfer rules.
    task automatic edge_step();
        bit do_push, do_pop;
        do_push = in_valid && (q.size() < DEPTH) && !flush;
        do_pop  = (q.size() > 0) && !flush && out_ready;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({in_pc, in_inst});
        end
    endtask

    task automatic fill_two(input logic [W-1:0] base);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, base + 32'(4*i), 32'h0000_0013 + 32'(i), 1'b0, 1'b0);
            edge_step();
        end
    endtask

    task automatic test_reset();
        tests++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            fails++; $display("FAIL reset_init: count=%0d ov=%b ir=%b pc=%h inst=%h, want 0 0 1 0 0", count, out_valid, in_ready, out_pc, out_inst);
        end
        @(negedge clk); rstn = 1'b0;
        fill_two(32'h8000_0040);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (count !== 2'd2) begin fails++; $display("FAIL reset_prefill: count=%0d want 2", count); end
        #2 rstn = 1'b1;
        #1;
        q.delete();
        tests++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            fails++; $display("FAIL reset_async: count=%0d ov=%b ir=%b pc=%h inst=%h, want 0 0 1 0 0", count, out_valid, in_ready, out_pc, out_inst);
        end
        @(negedge clk); rstn = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b1, 32'h8000_0000, 32'h0000_0413, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL single_nobypass: out_valid=%b want 0", out_valid); end
        edge_step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== 32'h0000_0413 || count !== 2'd1) begin
            fails++; $display("FAIL single_out: ov=%b pc=%h inst=%h count=%0d want 1 80000000 00000413 1", out_valid, out_pc, out_inst, count);
        end
        edge_step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL single_pop: count=%0d ov=%b want 0 0", count, out_valid); end
    endtask

    task automatic test_fill_stall();
        logic [W-1:0] exp_pc [3] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        int got = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, exp_pc[i], 32'h100 + 32'(i), 1'b0, 1'b0);
            if (i == 2) begin
                tests++;
                if (in_ready !== 1'b0 || count !== 2'd2) begin fails++; $display("FAIL stall_full: ir=%b count=%0d want 0 2", in_ready, count); end
            end
            edge_step();
        end
        // Hold the third request while draining; it only enters once a slot frees.
        for (int c = 0; c < 6 && got < 3; c++) begin
            drive(got < 2 || q.size() < 2 ? (c < 2 ? 1'b1 : 1'b0) : 1'b1, exp_pc[2], 32'h102, 1'b1, 1'b0);
            if (c == 0) begin
                tests++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_nopass: in_ready=%b want 0", in_ready); end
            end
            if (out_valid) begin
                tests++;
                if (out_pc !== exp_pc[got]) begin fails++; $display("FAIL stall_order: pc=%h want %h", out_pc, exp_pc[got]); end
                got++;
            end
            edge_step();
        end
        tests++;
        if (got != 3) begin fails++; $display("FAIL stall_drain: drained %0d want 3", got); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_stream();
        for (int k = 0; k < 9; k++) begin
            drive(k < 8, 32'h8000_0000 + 32'(4*k), 32'h200 + 32'(k), 1'b1, 1'b0);
            if (k >= 1) begin
                tests++;
                if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 + 32'(4*(k-1)) || out_inst !== 32'h200 + 32'(k-1) || count !== 2'd1) begin
                    fails++; $display("FAIL stream_%0d: ov=%b pc=%h inst=%h count=%0d want pc %h", k, out_valid, out_pc, out_inst, count, 32'h8000_0000 + 32'(4*(k-1)));
                end
            end
            edge_step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (count !== 2'd0) begin fails++; $display("FAIL stream_end: count=%0d want 0", count); end
    endtask

    task automatic test_flush();
        fill_two(32'h8000_0080);
        drive(1'b1, 32'h8000_0100, 32'h300, 1'b1, 1'b1);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ov: out_valid=%b want 0", out_valid); end
        edge_step();
        drive(1'b1, 32'h8000_0104, 32'h301, 1'b0, 1'b1);   // back-to-back flush
        tests++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_cnt: count=%0d ov=%b want 0 0", count, out_valid); end
        edge_step();
        drive(1'b1, 32'h8000_0200, 32'h302, 1'b0, 1'b0);
        tests++;
        if (count !== 2'd0) begin fails++; $display("FAIL flush_b2b: count=%0d want 0", count); end
        edge_step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_0200 || out_inst !== 32'h302 || count !== 2'd1) begin
            fails++; $display("FAIL flush_next: ov=%b pc=%h inst=%h count=%0d want 1 80000200 302 1", out_valid, out_pc, out_inst, count);
        end
        edge_step();
    endtask

    task automatic test_full_push_pop();
        fill_two(32'h8000_0400);
        drive(1'b1, 32'h8000_0500, 32'h400, 1'b1, 1'b0);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h8000_0400) begin
            fails++; $display("FAIL fpp_pre: ir=%b ov=%b pc=%h want 0 1 80000400", in_ready, out_valid, out_pc);
        end
        edge_step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (count !== 2'd1 || in_ready !== 1'b1 || out_pc !== 32'h8000_0404) begin
            fails++; $display("FAIL fpp_post: count=%0d ir=%b pc=%h want 1 1 80000404", count, in_ready, out_pc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        edge_step();
    endtask

    task automatic test_random();
        logic [63:0] head;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0);
            tests++;
            if (count !== 2'(q.size()) || in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() > 0 && !flush)) begin
                fails++; $display("FAIL rand_ctl@%0d: count=%0d ir=%b ov=%b want %0d %b %b", c, count, in_ready, out_valid, q.size(), q.size() < DEPTH, q.size() > 0 && !flush);
            end
            if (q.size() > 0) begin
                head = q[0];
                tests++;
                if (out_pc !== head[63:32] || out_inst !== head[31:0]) begin
                    fails++; $display("FAIL rand_data@%0d: pc=%h inst=%h want %h %h", c, out_pc, out_inst, head[63:32], head[31:0]);
                end
            end
            edge_step();
        end
    endtask

    initial begin
        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
        #12;
        test_reset();
        test_single();
        test_fill_stall();
        test_stream();
        test_flush();
        test_full_push_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
